// File: rtl/movement_control.sv
// Movement controller for a sprite datapath. On each movement tick the
// controller samples the direction buttons and, if they describe a net move,
// runs the sequence CLEAR -> [horizontal move] -> [vertical move] -> DRAW,
// waiting on the datapath's done flag in CLEAR and DRAW. A bounded wait in
// those two states raises a sticky fault and drops back to HOLD.
//
// Handshake: done is a level, sampled only in CLEAR and DRAW; a state moves
// on the first rising clk edge at which done=1 is seen and ignores it
// everywhere else. The control code is the state register itself.
module movement_control #(
    parameter int TICK_DIV = 833333,
    parameter int TIMEOUT  = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    input  logic       done,
    output logic [3:0] control,
    output logic       busy,
    output logic       fault
);

    localparam int             CW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  TICK_LAST  = CW'(TICK_DIV - 1);
    localparam logic [7:0]     WAIT_LAST  = 8'(TIMEOUT - 1);

    // Encodings are consumed directly by the datapath as its control word.
    typedef enum logic [3:0] {
        ST_HOLD    = 4'b0000,
        ST_CLEAR   = 4'b0001,
        ST_RIGHT   = 4'b0010,
        ST_LEFT    = 4'b0011,
        ST_PREHOLD = 4'b0100,
        ST_DRAW    = 4'b0101,
        ST_DOWN    = 4'b0110,
        ST_UP      = 4'b0111
    } state_e;

    state_e         state_q;
    logic [CW-1:0]  tick_cnt_q;
    logic           pending_q;
    logic [3:0]     dir_q;      // {left, right, up, down} latched at HOLD exit
    logic [7:0]     wait_q;
    logic           fault_q;

    logic [3:0]     req;
    logic           tick;
    logic           take;
    logic           req_move;
    logic           dir_left;
    logic           dir_right;
    logic           dir_up;
    logic           dir_has_v;
    logic           wait_expired;

    assign req          = {left, right, up, down};
    assign tick         = (tick_cnt_q == TICK_LAST);
    assign take         = (state_q == ST_HOLD) && pending_q;
    // Opposing pairs cancel, so a move exists only when exactly one of a pair is pressed.
    assign req_move     = (req[3] ^ req[2]) | (req[1] ^ req[0]);
    assign dir_left     = dir_q[3] & ~dir_q[2];
    assign dir_right    = dir_q[2] & ~dir_q[3];
    assign dir_up       = dir_q[1] & ~dir_q[0];
    assign dir_has_v    = dir_q[1] ^ dir_q[0];
    assign wait_expired = (wait_q == WAIT_LAST);

    assign control = state_q;
    assign busy    = (state_q != ST_HOLD);
    assign fault   = fault_q;

    // Free-running tick divider, independent of the FSM state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
        end
    end

    // Pending tick flag: ticks merge while set; consumed by HOLD. A tick on the
    // consuming cycle wins so it is not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= 1'b0;
        end else if (tick) begin
            pending_q <= 1'b1;
        end else if (take) begin
            pending_q <= 1'b0;
        end
    end

    // Main sequencer: state, latched direction, wait counter and sticky fault.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_PREHOLD;
            dir_q   <= 4'b0000;
            wait_q  <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            case (state_q)
                ST_PREHOLD: begin
                    state_q <= ST_DRAW;
                    wait_q  <= 8'd0;
                end
                ST_HOLD: begin
                    if (pending_q) begin
                        dir_q <= req;
                        if (req_move) begin
                            state_q <= ST_CLEAR;
                            wait_q  <= 8'd0;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (done) begin
                        if (dir_left)       state_q <= ST_LEFT;
                        else if (dir_right) state_q <= ST_RIGHT;
                        else if (dir_up)    state_q <= ST_UP;
                        else                state_q <= ST_DOWN;
                    end else if (wait_expired) begin
                        fault_q <= 1'b1;
                        state_q <= ST_HOLD;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                ST_LEFT, ST_RIGHT: begin
                    wait_q <= 8'd0;
                    if (dir_has_v) state_q <= dir_up ? ST_UP : ST_DOWN;
                    else           state_q <= ST_DRAW;
                end
                ST_UP, ST_DOWN: begin
                    wait_q  <= 8'd0;
                    state_q <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (done) begin
                        state_q <= ST_HOLD;
                    end else if (wait_expired) begin
                        fault_q <= 1'b1;
                        state_q <= ST_HOLD;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                default: state_q <= ST_PREHOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_movement_control.sv
// Directed bench for movement_control with a 10-cycle tick and 40-cycle
// done timeout. Inputs change and outputs are sampled on the falling edge.
module tb_movement_control;

    localparam int TICK_DIV = 10;
    localparam int TIMEOUT  = 40;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
    logic       done = 1'b0;
    logic [3:0] control;
    logic       busy;
    logic       fault;

    int n_total = 0;
    int n_bad   = 0;

    // Clock and global watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    movement_control #(.TICK_DIV(TICK_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .left(left), .right(right), .up(up), .down(down),
        .done(done), .control(control), .busy(busy), .fault(fault)
    );

    // Hold reset for a few cycles, release on a falling edge (call it N0).
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        done = 1'b0;
        left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Bounded wait for control to leave HOLD.
    task automatic wait_leave_hold();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (control !== 4'h0) break;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_total++; if (control !== 4'h4) begin n_bad++; $display("FAIL rst_control: got %b expected 0100", control); end
        n_total++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy: got %b expected 1", busy); end
        n_total++; if (fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %b expected 0", fault); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_total++; if (control !== 4'h4) begin n_bad++; $display("FAIL prehold: got %b expected 0100", control); end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            n_total++; if (control !== 4'h5 || busy !== 1'b1) begin n_bad++; $display("FAIL init_draw[%0d]: got %b/%b expected 0101/1", k, control, busy); end
            if (k == 16) done = 1'b1;
        end
        @(negedge clk);
        n_total++; if (control !== 4'h0) begin n_bad++; $display("FAIL init_hold: got %b expected 0000", control); end
        n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL init_busy: got %b expected 0", busy); end
        done = 1'b0;
    endtask

    // From a fresh reset ticks land on rising edges 10, 20, 30, 40. The initial
    // DRAW is held through three of them; exactly one sequence follows, and the
    // next CLEAR waits for the tick at edge 40.
    task automatic test_merge_ticks();
        logic [3:0] exp_tab [11];
        exp_tab = '{4'h0, 4'h1, 4'h6, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
        do_reset();
        down = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            n_total++; if (control !== 4'h5) begin n_bad++; $display("FAIL long_draw[%0d]: got %b expected 0101", k, control); end
        end
        done = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            n_total++; if (control !== exp_tab[i]) begin n_bad++; $display("FAIL merge[%0d]: got %b expected %b", 31 + i, control, exp_tab[i]); end
        end
        down = 1'b0;
        repeat (4) @(negedge clk);
        done = 1'b0;
        n_total++; if (control !== 4'h0) begin n_bad++; $display("FAIL merge_end: got %b expected 0000", control); end
    endtask

    task automatic test_left_up();
        do_reset();
        done = 1'b1;
        repeat (2) @(negedge clk);
        done = 1'b0;
        n_total++; if (control !== 4'h0) begin n_bad++; $display("FAIL lu_hold: got %b expected 0000", control); end
        left = 1'b1; up = 1'b1;
        wait_leave_hold();
        n_total++; if (control !== 4'h1) begin n_bad++; $display("FAIL lu_clear: got %b expected 0001", control); end
        // Opposite request mid-sequence must not alter the latched direction.
        left = 1'b0; up = 1'b0; right = 1'b1; down = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_total++; if (control !== 4'h1) begin n_bad++; $display("FAIL lu_clear_wait[%0d]: got %b expected 0001", k, control); end
        end
        done = 1'b1;
        @(negedge clk);
        n_total++; if (control !== 4'h3) begin n_bad++; $display("FAIL lu_left: got %b expected 0011", control); end
        done = 1'b0;
        @(negedge clk);
        n_total++; if (control !== 4'h7) begin n_bad++; $display("FAIL lu_up: got %b expected 0111", control); end
        @(negedge clk);
        n_total++; if (control !== 4'h5) begin n_bad++; $display("FAIL lu_draw: got %b expected 0101", control); end
        right = 1'b0; down = 1'b0;
        @(negedge clk);
        n_total++; if (control !== 4'h5) begin n_bad++; $display("FAIL lu_draw_wait: got %b expected 0101", control); end
        done = 1'b1;
        @(negedge clk);
        n_total++; if (control !== 4'h0) begin n_bad++; $display("FAIL lu_hold_end: got %b expected 0000", control); end
        done = 1'b0;
    endtask

    task automatic test_opposing();
        left = 1'b1; right = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            n_total++; if (control !== 4'h0) begin n_bad++; $display("FAIL opp_lr[%0d]: got %b expected 0000", k, control); end
        end
        up = 1'b1; down = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_total++; if (control !== 4'h0) begin n_bad++; $display("FAIL opp_all[%0d]: got %b expected 0000", k, control); end
        end
        left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0;
    endtask

    task automatic test_timeout();
        int cnt;
        right = 1'b1;
        wait_leave_hold();
        n_total++; if (control !== 4'h1) begin n_bad++; $display("FAIL to_clear: got %b expected 0001", control); end
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (control === 4'h1) cnt++;
            else break;
        end
        n_total++; if (cnt != TIMEOUT) begin n_bad++; $display("FAIL to_cycles: got %0d expected %0d", cnt, TIMEOUT); end
        n_total++; if (control !== 4'h0) begin n_bad++; $display("FAIL to_hold: got %b expected 0000", control); end
        n_total++; if (fault !== 1'b1) begin n_bad++; $display("FAIL to_fault: got %b expected 1", fault); end
        wait_leave_hold();
        n_total++; if (control !== 4'h1) begin n_bad++; $display("FAIL to_reclear: got %b expected 0001", control); end
        n_total++; if (fault !== 1'b1) begin n_bad++; $display("FAIL to_fault_sticky: got %b expected 1", fault); end
        done = 1'b1;
        @(negedge clk);
        n_total++; if (control !== 4'h2) begin n_bad++; $display("FAIL to_right: got %b expected 0010", control); end
        done = 1'b0;
        right = 1'b0;
        @(negedge clk);
        n_total++; if (control !== 4'h5) begin n_bad++; $display("FAIL to_draw: got %b expected 0101", control); end
        done = 1'b1;
        @(negedge clk);
        n_total++; if (control !== 4'h0) begin n_bad++; $display("FAIL to_done: got %b expected 0000", control); end
        done = 1'b0;
    endtask

    task automatic test_reset_mid_move();
        down = 1'b1;
        wait_leave_hold();
        n_total++; if (control !== 4'h1) begin n_bad++; $display("FAIL rm_clear: got %b expected 0001", control); end
        done = 1'b1;
        @(negedge clk);
        n_total++; if (control !== 4'h6) begin n_bad++; $display("FAIL rm_down: got %b expected 0110", control); end
        reset_n = 1'b0;
        down = 1'b0; done = 1'b0;
        #1;
        n_total++; if (control !== 4'h4) begin n_bad++; $display("FAIL rm_async: got %b expected 0100", control); end
        n_total++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rm_busy: got %b expected 1", busy); end
        n_total++; if (fault !== 1'b0) begin n_bad++; $display("FAIL rm_fault: got %b expected 0", fault); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_total++; if (control !== 4'h4) begin n_bad++; $display("FAIL rm_held[%0d]: got %b expected 0100", k, control); end
        end
        reset_n = 1'b1;
        #1;
        n_total++; if (control !== 4'h4) begin n_bad++; $display("FAIL rm_prehold: got %b expected 0100", control); end
        @(negedge clk);
        n_total++; if (control !== 4'h5) begin n_bad++; $display("FAIL rm_draw: got %b expected 0101", control); end
        n_total++; if (fault !== 1'b0) begin n_bad++; $display("FAIL rm_fault_after: got %b expected 0", fault); end
        done = 1'b1;
        @(negedge clk);
        n_total++; if (control !== 4'h0) begin n_bad++; $display("FAIL rm_hold: got %b expected 0000", control); end
        done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_merge_ticks();
        test_left_up();
        test_opposing();
        test_timeout();
        test_reset_mid_move();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/movement_control.md
MOVEMENT_CONTROL -- requirements
Module: movement_control

Interface
REQ-001 Parameter TICK_DIV, default 833333, clk cycles per movement tick (60 Hz at 50 MHz); legal range 2..2^20.
REQ-002 Parameter TIMEOUT, default 64, max clk cycles spent in CLEAR or DRAW waiting for done; legal range 17..255.
REQ-003 clk  input  1  system clock; all state changes on posedge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 left, right, up, down  input  1 each  active-high direction requests, synchronous to clk.
REQ-006 done  input  1  datapath draw-complete flag (datapath enable output).
REQ-007 control  output  4  state code to the movement datapath.
REQ-008 busy  output  1  high whenever state is not HOLD.
REQ-009 fault  output  1  sticky done-timeout flag.

Function
REQ-010 State codes SHALL be: PREHOLD 0100, HOLD 0000, CLEAR 0001, LEFT 0011, RIGHT 0010, DOWN 0110, UP 0111, DRAW 0101.
REQ-011 control SHALL be driven directly from the state register, with no combinational path from any input.
REQ-012 A tick counter SHALL count 0..TICK_DIV-1 and wrap, asserting a one-cycle tick on the wrap cycle, free-running in every state.
REQ-013 tick SHALL set a pending flag; pending SHALL clear on the cycle HOLD is exited on a tick; multiple ticks while pending merge into one.
REQ-014 PREHOLD SHALL last exactly one cycle, then go to DRAW (initial sprite draw).
REQ-015 In HOLD with pending=1, the FSM SHALL latch left/right/up/down into a direction register and clear pending.
REQ-016 On that HOLD exit, if the latched request has no net move, the FSM SHALL stay in HOLD; otherwise it SHALL go to CLEAR.
REQ-017 No net move means none of the four requests pressed, or only the opposing pairs left&right and/or up&down pressed.
REQ-018 Net horizontal SHALL be left only -> LEFT, right only -> RIGHT, otherwise none; net vertical SHALL be up only -> UP, down only -> DOWN, otherwise none.
REQ-019 CLEAR SHALL persist until done=1 is sampled, then go to the horizontal move state if any, else the vertical move state.
REQ-020 Each move state SHALL last exactly one cycle; the horizontal move state SHALL be followed by the vertical move state if any, else by DRAW; the vertical move state SHALL be followed by DRAW.
REQ-021 DRAW SHALL persist until done=1 is sampled, then go to HOLD.
REQ-022 At least one move state SHALL separate CLEAR from DRAW, guaranteeing the datapath drops done before DRAW begins.
REQ-023 The direction register SHALL hold its value from the HOLD exit until the next HOLD exit; input changes mid-sequence SHALL be ignored.
REQ-024 An 8-bit wait counter SHALL reset to 0 on entry to CLEAR or DRAW and increment each cycle spent there.
REQ-025 If the wait counter reaches TIMEOUT-1 with done=0, the FSM SHALL set fault=1 and go to HOLD, abandoning the move.
REQ-026 fault SHALL remain 1 until reset; operation SHALL continue normally after a fault.
REQ-027 done SHALL be ignored in every state except CLEAR and DRAW.

Reset
REQ-028 reset_n=0 SHALL immediately force state=PREHOLD, control=0100, busy=1, fault=0, tick counter=0, pending=0, direction register=0, wait counter=0.
REQ-029 Reset asserted mid-sequence SHALL abort that sequence with no further move states issued; after release the FSM SHALL restart at PREHOLD.

Verification
REQ-030 Release reset, done pulses 16 cycles after DRAW entry -> control sequence 0100, 0101 (x16), 0000; busy falls on HOLD entry.
REQ-031 TICK_DIV=10, left=1 and up=1 held at tick -> sequence 0001 until done, 0011 (1 cycle), 0111 (1 cycle), 0101 until done, 0000.
REQ-032 left=right=1 at tick -> FSM stays in HOLD, control=0000 throughout, pending cleared.
REQ-033 right=1 at tick, done never asserted -> after TIMEOUT cycles in CLEAR, fault=1 and control=0000; next tick with right=1 starts CLEAR again.
REQ-034 Three ticks arrive during one long DRAW -> exactly one further sequence starts from the next HOLD.
REQ-035 reset_n pulsed low during DOWN -> control=0100 during reset, no 0101 until PREHOLD has elapsed, fault=0.
